store_merge: RTL and testbench

STORE_MERGE -- requirements
Module: store_merge

---
 rtl/store_merge.sv | 142 ++++++++++++++
 tb/tb_store_merge.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/store_merge.sv
// store_merge: sub-word store unit doing read-modify-write of a 32-bit word memory.
// SW writes directly; SH/SB read the word, merge the lane, then write it back.
module store_merge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [1:0]        st_funct,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);
    typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [15:0]       data_q, data_d;
    logic              sb_q, sb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              bad;
    logic [31:0]       merged;

    assign bad = (st_funct == 2'b11) || (st_funct == 2'b01 && addr[0]) ||
                 (st_funct == 2'b00 && addr[1:0] != 2'b00);

    // Little-endian lane replacement over the word returned by the read.
    always_comb begin
        merged = mem_rdata;
        if (sb_q)
            merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
        else
            merged[{lane_q[1], 4'b0000} +: 16] = data_q;
    end

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        data_d      = data_q;
        sb_d        = sb_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        misalign_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: if (req) begin
                lane_d     = addr[1:0];
                data_d     = wdata[15:0];
                sb_d       = st_funct == 2'b10;
                mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
                busy_d     = 1'b1;
                if (bad) begin
                    state_d    = ERR;
                    misalign_d = 1'b1;
                end else if (st_funct == 2'b00) begin
                    state_d     = WRITE;
                    mem_wr_d    = 1'b1;
                    mem_wdata_d = wdata;
                end else begin
                    state_d  = READ;
                    mem_rd_d = 1'b1;
                end
            end
            READ: if (mem_ack) begin
                state_d     = WRITE;
                mem_rd_d    = 1'b0;
                mem_wr_d    = 1'b1;
                mem_wdata_d = merged;
            end
            WRITE: if (mem_ack) begin
                state_d     = DONE;
                mem_wr_d    = 1'b0;
                mem_wdata_d = 32'h0;
                done_d      = 1'b1;
            end
            DONE, ERR: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                mem_rd_d    = 1'b0;
                mem_wr_d    = 1'b0;
                mem_wdata_d = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lane_q      <= 2'b00;
            data_q      <= 16'h0;
            sb_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            data_q      <= data_d;
            sb_q        <= sb_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            misalign_q  <= misalign_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign misalign  = misalign_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_store_merge.sv
// tb_store_merge: randomized store traffic against a lane-merge reference model;
// a monitor pops expected memory/done/error events from a scoreboard queue.
module tb_store_merge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  st_funct = '0;
    logic        busy, done, misalign, mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;
    ev_t sb_q[$];

    int n_chk = 0;
    int n_pass = 0;

    store_merge #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .wdata(wdata),
        .st_funct(st_funct), .busy(busy), .done(done), .misalign(misalign),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic bit is_bad(input logic [31:0] a, input logic [1:0] f);
        return f == 2'd3 || (f == 2'd1 && a % 2 != 0) || (f == 2'd0 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] a, input logic [31:0] w,
                                                input logic [1:0] f, input logic [31:0] rd);
        int          sh;
        logic [31:0] m;
        if (f == 2'd0) return w;
        sh = (f == 2'd2) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
        m  = ((f == 2'd2) ? 32'hFF : 32'hFFFF) << sh;
        return (rd & ~m) | ((w << sh) & m);
    endfunction

    function automatic ev_t mk(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.d    = d;
        return e;
    endfunction

    // Called at posedge+1; drives the request, plays the memory, checks latency.
    task automatic do_store(input logic [31:0] a, input logic [31:0] w, input logic [1:0] f,
                            input logic [31:0] rd, input int rwait, input int wwait, input bit extra);
        int          cyc = 0, rcnt = 0, wcnt = 0, rd_cnt = 0;
        int          first_rd = -1, first_wr = -1, done_c = -1, err_c = -1;
        logic [31:0] wa;
        wa = a & 32'hFFFF_FFFC;
        if (is_bad(a, f)) sb_q.push_back(mk(3, 0, 0));
        else begin
            if (f != 2'd0) sb_q.push_back(mk(0, wa, 0));
            sb_q.push_back(mk(1, wa, model_merge(a, w, f, rd)));
            sb_q.push_back(mk(2, 0, 0));
        end
        req = 1'b1; addr = a; wdata = w; st_funct = f;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            addr = $urandom; wdata = $urandom; st_funct = 2'($urandom);
            if (mem_rd) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (mem_wr && first_wr < 0) first_wr = cyc;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (mem_rd) begin
                if (rcnt == rwait) begin mem_ack = 1'b1; mem_rdata = rd; end
                else rcnt++;
            end else if (mem_wr) begin
                if (wcnt == wwait) mem_ack = 1'b1;
                else wcnt++;
            end
            req = extra && busy ? 1'($urandom) : 1'b0;
            if (done) begin done_c = cyc; break; end
            if (misalign) begin err_c = cyc; break; end
        end
        req = 1'b0;
        mem_ack = 1'b0;
        if (is_bad(a, f)) begin
            chk(err_c == 1, "misalign_cycle", err_c, 1);
            chk(first_rd < 0 && first_wr < 0 && done_c < 0, "err_no_access", first_wr, -1);
        end else if (f == 2'd0) begin
            chk(first_rd < 0, "sw_no_read", first_rd, -1);
            chk(first_wr == 1, "sw_wr_cycle", first_wr, 1);
            chk(done_c == 2 + wwait, "sw_done_cycle", done_c, 2 + wwait);
        end else begin
            chk(first_rd == 1, "rmw_rd_cycle", first_rd, 1);
            chk(rd_cnt == rwait + 1, "rmw_rd_len", rd_cnt, rwait + 1);
            chk(first_wr == 2 + rwait, "rmw_wr_cycle", first_wr, 2 + rwait);
            chk(done_c == 3 + rwait + wwait, "rmw_done_cycle", done_c, 3 + rwait + wwait);
        end
        @(posedge clk); #1;
        chk(!busy, "idle_after", busy, 0);
    endtask

    // Monitor: pops the scoreboard for each memory completion, done and error pulse.
    logic        p_rd = 1'b0, p_wr = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            p_rd = 1'b0; p_wr = 1'b0;
        end else begin
            if (mem_rd && mem_wr) chk(1'b0, "rd_wr_overlap", 1, 0);
            if (!mem_wr && mem_wdata != 0) chk(1'b0, "wdata_idle_zero", mem_wdata, 0);
            if (p_rd && mem_rd) chk(mem_addr == p_addr, "rd_addr_stable", mem_addr, p_addr);
            if (p_wr && mem_wr)
                chk(mem_addr == p_addr && mem_wdata == p_wdata, "wr_stable", mem_wdata, p_wdata);
            for (int k = 0; k < 4; k++) begin
                if ((k == 0 && mem_rd && mem_ack) || (k == 1 && mem_wr && mem_ack) ||
                    (k == 2 && done) || (k == 3 && misalign)) begin
                    if (sb_q.size() == 0) chk(1'b0, "unexpected_event", k, 32'hFFFF_FFFF);
                    else begin
                        e = sb_q.pop_front();
                        chk(e.kind == k, "event_kind", k, e.kind);
                        if (k == 0) chk(mem_addr == e.a, "rd_addr", mem_addr, e.a);
                        if (k == 1) chk(mem_addr == e.a, "wr_addr", mem_addr, e.a);
                        if (k == 1) chk(mem_wdata == e.d, "wr_data", mem_wdata, e.d);
                    end
                end
            end
            p_rd = mem_rd; p_wr = mem_wr; p_addr = mem_addr; p_wdata = mem_wdata;
        end
    end

    initial begin
        #1;
        chk(!busy && !done && !misalign && !mem_rd && !mem_wr && mem_addr == 0 && mem_wdata == 0,
            "reset_outputs", {busy, done, misalign, mem_rd, mem_wr}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_store(32'h1003, 32'h0000_00AB, 2'd2, 32'h1122_3344, 0, 0, 0);
        do_store(32'h2002, 32'h0000_BEEF, 2'd1, 32'h1122_3344, 0, 0, 0);
        do_store(32'h2000, 32'h0000_BEEF, 2'd1, 32'h1122_3344, 0, 0, 0);
        do_store(32'h3000, 32'hDEAD_BEEF, 2'd0, 32'h0, 0, 0, 0);
        do_store(32'h0001, 32'h1234_5678, 2'd1, 32'h0, 0, 0, 0);
        do_store(32'h0002, 32'h1234_5678, 2'd0, 32'h0, 0, 0, 0);
        do_store(32'h0000, 32'h1234_5678, 2'd3, 32'h0, 0, 0, 0);
        do_store(32'h4001, 32'h0000_0055, 2'd2, 32'hCAFE_F00D, 3, 0, 1);
        // Abort a pending write with reset: no write completion or done expected.
        req = 1'b1; addr = 32'h3000; wdata = 32'h0BAD_0BAD; st_funct = 2'd0;
        @(posedge clk); #1;
        req = 1'b0;
        chk(mem_wr, "abort_wr_started", mem_wr, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk(!mem_wr && !busy && !done && mem_addr == 0 && mem_wdata == 0,
            "reset_midwrite", {mem_wr, busy}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_store(32'h3000, 32'hDEAD_BEEF, 2'd0, 32'h0, 0, 1, 0);
        for (int i = 0; i < 40; i++)
            do_store($urandom, $urandom, 2'($urandom), $urandom,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
        repeat (3) @(posedge clk);
        chk(sb_q.size() == 0, "scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
